key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, is the number of consecutive stable synchronized samples that confirm a press or a release (20 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter LONG_CYCLES, default 50_000_000, is the number of cycles after press confirmation at which long_pulse fires (1 s at 50 MHz); legal range > DEBOUNCE_CYCLES.
REQ-003 Port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 Port key_in, input, 1 bit: raw asynchronous push-button; active-low, so 0 means pressed.
REQ-006 Port key_level, output, 1 bit: debounced state; 1 means pressed.
REQ-007 Port press_pulse, output, 1 bit: one-cycle strobe on each confirmed press.
REQ-008 Port release_pulse, output, 1 bit: one-cycle strobe on each confirmed release.
REQ-009 Port long_pulse, output, 1 bit: one-cycle strobe when a press has been held LONG_CYCLES.
REQ-010 Port press_count, output, 8 bits: count of confirmed presses, wrapping modulo 256.

Function
REQ-011 key_in SHALL pass through a two-flop synchronizer (s1, s2) before any other logic uses it.
REQ-012 The FSM SHALL have exactly four states: IDLE, PRESS_FILTER, PRESSED, RELEASE_FILTER.
REQ-013 IDLE: when s2 = 0, go to PRESS_FILTER with the debounce counter at 1; otherwise stay in IDLE.
REQ-014 PRESS_FILTER: s2 = 1 returns to IDLE with the counter cleared; s2 = 0 increments the counter; when the counter reaches DEBOUNCE_CYCLES, go to PRESSED.
REQ-015 On entering PRESSED from PRESS_FILTER: key_level <= 1, press_pulse <= 1 for one cycle, press_count increments by 1, and the hold counter clears.
REQ-016 Latency: if key_in stays low, key_level and press_pulse SHALL be visible after the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples key_in = 0.
REQ-017 PRESSED: s2 = 1 goes to RELEASE_FILTER with the debounce counter at 1.
REQ-018 RELEASE_FILTER: s2 = 0 returns to PRESSED with key_level held at 1 and no pulse; after DEBOUNCE_CYCLES consecutive samples of s2 = 1, go to IDLE with key_level <= 0 and release_pulse <= 1 for one cycle.
REQ-019 Release latency SHALL mirror REQ-016 (DEBOUNCE_CYCLES+2 edges after key_in first samples 1).
REQ-020 The hold counter SHALL increment in PRESSED and in RELEASE_FILTER, and saturate once it reaches LONG_CYCLES.
REQ-021 long_pulse SHALL assert for exactly one cycle, on the edge where the hold counter reaches LONG_CYCLES; this is exactly LONG_CYCLES edges after the press_pulse edge.
REQ-022 long_pulse SHALL fire at most once per press, may fire during RELEASE_FILTER, and SHALL NOT fire if the release is confirmed first.
REQ-023 press_pulse, release_pulse and long_pulse SHALL never assert in the same cycle as each other.
REQ-024 press_count SHALL wrap from 255 to 0 with no other side effect.
REQ-025 Counter widths SHALL be $clog2 of the respective parameter + 1; counters SHALL never overflow.

Reset
REQ-026 While rst_n = 0 at a rising edge, the following SHALL take their reset values at that edge:
- s1 = 1, s2 = 1
- state = IDLE
- all counters = 0
- key_level = 0, press_pulse = 0, release_pulse = 0, long_pulse = 0
- press_count = 0
REQ-027 Reset asserted mid-operation SHALL abandon any filter or hold in progress without emitting a pulse.
REQ-028 If key_in is held low through reset release, a fresh press SHALL be confirmed per REQ-016, counted from the first edge with rst_n = 1.

Verification (bench parameters DEBOUNCE_CYCLES = 4, LONG_CYCLES = 20, 20 ns clock)
REQ-029 Clean press and release:
- key_in drops and holds low for 15 cycles -> press_pulse on edge 6, key_level = 1, press_count = 1.
- key_in then rises -> release_pulse 6 edges later, key_level = 0, and no long_pulse.
REQ-030 Press bounce: key_in low 3, high 1, low 2, high 1, then low steady -> exactly one press_pulse, on the 6th edge of the steady low.
REQ-031 Long press: key_in held low 40 cycles -> one press_pulse, then exactly one long_pulse 20 edges after it, then one release_pulse after key_in rises.
REQ-032 Release glitch: while pressed, key_in high for 2 cycles then low -> key_level stays 1, and no release_pulse or press_pulse occurs.
REQ-033 Mid-filter reset: rst_n = 0 for 2 cycles on the 3rd low edge, with key_in held low -> all outputs are 0 during reset, and press_pulse occurs on the 6th edge after rst_n returns to 1.
REQ-034 Wrap: 256 clean press/release cycles -> press_count returns to 0 and exactly 256 press_pulse strobes are observed.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button debouncer. It synchronises an active-low key, confirms presses and releases
// with a four-state filter FSM, and emits press, release and long-hold strobes plus a press counter.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES) + 1;

  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILTER,
    PRESSED,
    RELEASE_FILTER
  } state_e;

  logic              s1_q, s2_q;
  state_e            state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic [7:0]        count_q, count_d;
  logic              confirm_press, confirm_release;

  // The synchroniser resets to the released level, so a key held low through reset
  // still has to pass the full filter before it counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      s1_q <= key_in;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The filter confirms on the edge that would bring the counter to DEBOUNCE_CYCLES.
  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    unique case (state_q)
      IDLE: begin
        db_cnt_d = '0;
        if (!s2_q) begin
          state_d  = PRESS_FILTER;
          db_cnt_d = DB_ONE;
        end
      end
      PRESS_FILTER: begin
        if (s2_q) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      PRESSED: begin
        if (s2_q) begin
          state_d  = RELEASE_FILTER;
          db_cnt_d = DB_ONE;
        end
      end
      RELEASE_FILTER: begin
        if (!s2_q) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  assign confirm_press   = (state_q == PRESS_FILTER)   && (state_d == PRESSED);
  assign confirm_release = (state_q == RELEASE_FILTER) && (state_d == IDLE);

  // A confirmed release wins over a hold that would saturate on the same edge.
  always_comb begin
    level_d   = (state_d == PRESSED) || (state_d == RELEASE_FILTER);
    press_d   = confirm_press;
    release_d = confirm_release;
    count_d   = confirm_press ? count_q + 8'd1 : count_q;
    hold_d    = '0;
    long_d    = 1'b0;
    if ((state_q == PRESSED) || (state_q == RELEASE_FILTER)) begin
      if (confirm_release) begin
        hold_d = '0;
      end else if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + HOLD_ONE;
        long_d = (hold_q == HOLD_LAST);
      end else begin
        hold_d = hold_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt_q  <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      count_q   <= count_d;
    end
  end

  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce. A window-based behavioural model is checked
// every cycle, and fixed scenarios pin pulse timing with hand-computed edge offsets.
module tb_key_debounce;

  localparam int D = 4;
  localparam int L = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_in = 1'b1;
  logic       key_level, press_pulse, release_pulse, long_pulse;
  logic [7:0] press_count;

  key_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: the key reaches the filter two edges late, and the level flips
  // once the last D filtered samples all disagree with it.
  bit m_valid = 1'b0;
  bit m_level, m_press, m_release, m_long;
  int m_count, m_since;
  bit m_pipe[$];
  bit m_win[$];

  int n_press = 0, n_release = 0, n_long = 0;
  int last_press_cyc = -1000, last_release_cyc = -1000, last_long_cyc = -1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit k, input bit r);
    bit seen, old, flip;
    if (!r) begin
      m_valid = 1'b1;
      {m_level, m_press, m_release, m_long} = '0;
      m_count = 0;
      m_since = 0;
      m_pipe.delete();
      m_pipe.push_back(1'b1);
      m_pipe.push_back(1'b1);
      m_win.delete();
      for (int i = 0; i < D; i++) m_win.push_back(1'b1);
      return;
    end
    if (!m_valid) return;
    m_pipe.push_back(k);
    seen = m_pipe.pop_front();
    m_win.push_back(seen);
    void'(m_win.pop_front());
    flip = 1'b1;
    foreach (m_win[i]) if ((!m_win[i]) == m_level) flip = 1'b0;
    old = m_level;
    if (flip) m_level = !m_level;
    m_press   = !old && m_level;
    m_release = old && !m_level;
    m_long    = 1'b0;
    if (m_press) begin
      m_since = 0;
      m_count = (m_count + 1) % 256;
    end else if (m_level) begin
      m_since++;
      m_long = (m_since == L);
    end
  endtask

  task automatic step(input bit k, input bit r);
    key_in = k;
    rst_n  = r;
    @(posedge clk);
    cyc++;
    model_edge(k, r);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int s;
    if (m_valid) begin
      check("key_level", key_level, m_level);
      check("press_pulse", press_pulse, m_press);
      check("release_pulse", release_pulse, m_release);
      check("long_pulse", long_pulse, m_long);
      check("press_count", press_count, m_count);
      s = 0;
      if (press_pulse === 1'b1) s++;
      if (release_pulse === 1'b1) s++;
      if (long_pulse === 1'b1) s++;
      check("strobe_exclusive", s <= 1, 1);
      if (press_pulse === 1'b1) begin n_press++; last_press_cyc = cyc; end
      if (release_pulse === 1'b1) begin n_release++; last_release_cyc = cyc; end
      if (long_pulse === 1'b1) begin n_long++; last_long_cyc = cyc; end
    end
  end

  initial begin
    int t0, p0, r0, l0;
    bit k;
    int len;

    repeat (3) step(1'b1, 1'b0);
    check("reset_level", key_level, 0);
    check("reset_count", press_count, 0);
    check("reset_pulses", {press_pulse, release_pulse, long_pulse}, 0);
    repeat (3) step(1'b1, 1'b1);

    // Clean press then release
    t0 = cyc; p0 = n_press; l0 = n_long;
    repeat (15) step(1'b0, 1'b1);
    check("clean_press_edge", last_press_cyc - t0, 6);
    check("clean_press_level", key_level, 1);
    check("clean_press_count", press_count, 1);
    check("clean_press_num", n_press - p0, 1);
    t0 = cyc;
    repeat (12) step(1'b1, 1'b1);
    check("clean_release_edge", last_release_cyc - t0, 6);
    check("clean_release_level", key_level, 0);
    check("clean_no_long", n_long - l0, 0);

    // Bounce: low 3, high 1, low 2, high 1, then steady low
    t0 = cyc; p0 = n_press;
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b1);
    check("bounce_press_edge", last_press_cyc - t0, 13);
    check("bounce_press_num", n_press - p0, 1);
    repeat (12) step(1'b1, 1'b1);

    // Long press
    t0 = cyc; p0 = n_press; r0 = n_release; l0 = n_long;
    repeat (40) step(1'b0, 1'b1);
    check("long_press_edge", last_press_cyc - t0, 6);
    check("long_after_press", last_long_cyc - last_press_cyc, 20);
    check("long_num", n_long - l0, 1);
    repeat (12) step(1'b1, 1'b1);
    check("long_release_num", n_release - r0, 1);
    check("long_num_after_release", n_long - l0, 1);
    check("long_press_num", n_press - p0, 1);

    // Release glitch while pressed
    repeat (12) step(1'b0, 1'b1);
    p0 = n_press; r0 = n_release;
    repeat (2) step(1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b1);
    check("glitch_level", key_level, 1);
    check("glitch_no_release", n_release - r0, 0);
    check("glitch_no_press", n_press - p0, 0);
    repeat (12) step(1'b1, 1'b1);

    // Randomised runs with occasional reset
    for (int n = 0; n < 60; n++) begin
      k   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 6));
      repeat (len) step(k, 1'b1);
      if ($urandom_range(0, 19) == 0) step(k, 1'b0);
    end
    repeat (12) step(1'b1, 1'b1);

    // Reset in the middle of the press filter, key held low throughout
    p0 = n_press;
    repeat (2) step(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    check("midreset_count", press_count, 0);
    check("midreset_level", key_level, 0);
    t0 = cyc;
    repeat (10) step(1'b0, 1'b1);
    check("midreset_press_edge", last_press_cyc - t0, 6);
    check("midreset_press_num", n_press - p0, 1);
    check("midreset_count_after", press_count, 1);
    repeat (12) step(1'b1, 1'b1);

    // Wrap the press counter
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    p0 = n_press;
    repeat (256) begin
      repeat (7) step(1'b0, 1'b1);
      repeat (7) step(1'b1, 1'b1);
    end
    check("wrap_count", press_count, 0);
    check("wrap_press_num", n_press - p0, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
